// File: rtl/xif_offload_pkg.sv
// rtl/xif_offload_pkg.sv - shared types and defaults for the CV-X-IF offload controller
package xif_offload_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 256;
    localparam int XLEN_DEF           = 32;
    localparam int X_ID_WIDTH_DEF     = 4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_ISSUE  = 4'b0010,
        S_COMMIT = 4'b0100,
        S_RESULT = 4'b1000
    } state_t;

    typedef struct packed {
        logic [31:0]               instr;
        logic [XLEN_DEF-1:0]       rs1;
        logic [XLEN_DEF-1:0]       rs2;
        logic [X_ID_WIDTH_DEF-1:0] id;
        logic                      wb;
    } req_t;

endpackage

// File: rtl/xif_timeout_counter.sv
// rtl/xif_timeout_counter.sv - result-wait counter with clear, enable and terminal count
module xif_timeout_counter #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/xif_offload_ctrl.sv
// rtl/xif_offload_ctrl.sv - single-outstanding CV-X-IF initiator: issue, commit, result, writeback
module xif_offload_ctrl
    import xif_offload_pkg::*;
#(
    parameter int X_ID_WIDTH     = X_ID_WIDTH_DEF,
    parameter int XLEN           = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_instr_i,
    input  logic [XLEN-1:0]       req_rs1_i,
    input  logic [XLEN-1:0]       req_rs2_i,
    input  logic [X_ID_WIDTH-1:0] req_id_i,
    input  logic                  kill_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [31:0]           issue_instr_o,
    output logic [XLEN-1:0]       issue_rs0_o,
    output logic [XLEN-1:0]       issue_rs1_o,
    output logic [X_ID_WIDTH-1:0] issue_id_o,
    input  logic                  issue_accept_i,
    input  logic                  issue_writeback_i,
    output logic                  commit_valid_o,
    output logic [X_ID_WIDTH-1:0] commit_id_o,
    output logic                  commit_kill_o,
    input  logic                  result_valid_i,
    output logic                  result_ready_o,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    input  logic [XLEN-1:0]       result_data_i,
    input  logic [4:0]            result_rd_i,
    input  logic                  result_we_i,
    input  logic                  result_exc_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  illegal_o,
    output logic                  exc_o,
    output logic                  id_err_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    state_t state, state_next;
    req_t   req;
    logic   kill_pend;
    logic   id_match, res_hit, killed;
    logic   cnt_clr, cnt_en, cnt_tc;

    assign id_match = (result_id_i == X_ID_WIDTH'(req.id));
    assign res_hit  = (state == S_RESULT) && result_valid_i && id_match;
    assign killed   = kill_pend || kill_i;

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (req_valid_i) state_next = S_ISSUE;
            S_ISSUE:  if (issue_ready_i) state_next = issue_accept_i ? S_COMMIT : S_IDLE;
            S_COMMIT: state_next = killed ? S_IDLE : S_RESULT;
            S_RESULT: if (res_hit || cnt_tc) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign req_ready_o    = (state == S_IDLE);
    assign busy_o         = (state != S_IDLE);
    assign issue_valid_o  = (state == S_ISSUE);
    assign commit_valid_o = (state == S_COMMIT);
    assign commit_kill_o  = commit_valid_o && killed;
    assign result_ready_o = (state == S_RESULT);
    assign issue_instr_o  = req.instr;
    assign issue_rs0_o    = XLEN'(req.rs1);
    assign issue_rs1_o    = XLEN'(req.rs2);
    assign issue_id_o     = X_ID_WIDTH'(req.id);
    assign commit_id_o    = X_ID_WIDTH'(req.id);

    // A mismatching beat still counts toward the timeout; only a matching result stops it.
    assign cnt_clr = (state == S_COMMIT);
    assign cnt_en  = (state == S_RESULT) && !res_hit;

    xif_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk(clk_i),
        .rst(rst_i),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            req        <= '0;
            kill_pend  <= 1'b0;
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            illegal_o  <= 1'b0;
            exc_o      <= 1'b0;
            id_err_o   <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_next;
            wb_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            exc_o      <= 1'b0;
            id_err_o   <= 1'b0;
            timeout_o  <= (state == S_RESULT) && cnt_tc && !res_hit;
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req.instr <= req_instr_i;
                        req.rs1   <= XLEN_DEF'(req_rs1_i);
                        req.rs2   <= XLEN_DEF'(req_rs2_i);
                        req.id    <= X_ID_WIDTH_DEF'(req_id_i);
                        req.wb    <= 1'b0;
                        kill_pend <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    kill_pend <= killed;
                    if (issue_ready_i) begin
                        illegal_o <= !issue_accept_i;
                        req.wb    <= issue_writeback_i;
                    end
                end
                S_RESULT: begin
                    if (result_valid_i) begin
                        if (!id_match) begin
                            id_err_o <= 1'b1;
                        end else if (result_exc_i) begin
                            exc_o <= 1'b1;
                        end else if (result_we_i && req.wb && (result_rd_i != 5'd0)) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= result_rd_i;
                            wb_data_o  <= result_data_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// tb/tb_xif_offload_ctrl.sv - self-checking bench for xif_offload_ctrl
module tb_xif_offload_ctrl;

    localparam int XW = 32;
    localparam int IW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   req_instr = '0;
    logic [XW-1:0] req_rs1 = '0, req_rs2 = '0;
    logic [IW-1:0] req_id = '0;
    logic          kill = 1'b0;
    logic          issue_ready = 1'b0, issue_accept = 1'b0, issue_writeback = 1'b0;
    logic          result_valid = 1'b0;
    logic [IW-1:0] result_id = '0;
    logic [XW-1:0] result_data = '0;
    logic [4:0]    result_rd = '0;
    logic          result_we = 1'b0, result_exc = 1'b0;

    logic          req_ready_o, issue_valid_o, commit_valid_o, commit_kill_o, result_ready_o;
    logic [31:0]   issue_instr_o;
    logic [XW-1:0] issue_rs0_o, issue_rs1_o, wb_data_o;
    logic [IW-1:0] issue_id_o, commit_id_o;
    logic          wb_valid_o, illegal_o, exc_o, id_err_o, timeout_o, busy_o;
    logic [4:0]    wb_rd_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xif_offload_ctrl #(.X_ID_WIDTH(IW), .XLEN(XW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_instr_i(req_instr),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_id_i(req_id), .kill_i(kill),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready), .issue_instr_o(issue_instr_o),
        .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o), .issue_id_o(issue_id_o),
        .issue_accept_i(issue_accept), .issue_writeback_i(issue_writeback),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .result_valid_i(result_valid), .result_ready_o(result_ready_o), .result_id_i(result_id),
        .result_data_i(result_data), .result_rd_i(result_rd), .result_we_i(result_we),
        .result_exc_i(result_exc),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o), .exc_o(exc_o), .id_err_o(id_err_o), .timeout_o(timeout_o),
        .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 offering issue, 2 commit, 3 awaiting result.
    int            ph = 0;
    int            left = 0;
    logic          live = 1'b0;
    logic [31:0]   m_instr;
    logic [XW-1:0] m_rs1, m_rs2;
    logic [IW-1:0] m_id;
    logic          m_wb, m_kill;
    logic          e_illegal, e_exc, e_id_err, e_timeout, e_wb;
    logic [4:0]    e_rd;
    logic [XW-1:0] e_data;

    always @(posedge clk) begin
        {e_illegal, e_exc, e_id_err, e_timeout, e_wb} = '0;
        if (rst) begin
            ph = 0;
            live = 1'b1;
        end else begin
            case (ph)
                0: if (req_valid) begin
                    m_instr = req_instr; m_rs1 = req_rs1; m_rs2 = req_rs2; m_id = req_id;
                    m_kill = 1'b0; ph = 1;
                end
                1: begin
                    if (kill) m_kill = 1'b1;
                    if (issue_ready) begin
                        if (!issue_accept) begin e_illegal = 1'b1; ph = 0; end
                        else begin m_wb = issue_writeback; ph = 2; end
                    end
                end
                2: if (m_kill || kill) ph = 0; else begin ph = 3; left = TO; end
                default: begin
                    if (result_valid && result_id == m_id) begin
                        ph = 0;
                        if (result_exc) e_exc = 1'b1;
                        else if (result_we && m_wb && result_rd != 0) begin
                            e_wb = 1'b1; e_rd = result_rd; e_data = result_data;
                        end
                    end else begin
                        if (result_valid) e_id_err = 1'b1;
                        left--;
                        if (left == 0) begin e_timeout = 1'b1; ph = 0; end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("req_ready", req_ready_o, ph == 0);
            chk("busy", busy_o, ph != 0);
            chk("issue_valid", issue_valid_o, ph == 1);
            if (ph == 1) begin
                chk("issue_instr", issue_instr_o, m_instr);
                chk("issue_rs0", issue_rs0_o, m_rs1);
                chk("issue_rs1", issue_rs1_o, m_rs2);
                chk("issue_id", issue_id_o, m_id);
            end
            chk("commit_valid", commit_valid_o, ph == 2);
            if (ph == 2) chk("commit_id", commit_id_o, m_id);
            chk("commit_kill", commit_kill_o, (ph == 2) && (m_kill || kill));
            chk("result_ready", result_ready_o, ph == 3);
            chk("illegal", illegal_o, e_illegal);
            chk("exc", exc_o, e_exc);
            chk("id_err", id_err_o, e_id_err);
            chk("timeout", timeout_o, e_timeout);
            chk("wb_valid", wb_valid_o, e_wb);
            if (e_wb) begin
                chk("wb_rd", wb_rd_o, e_rd);
                chk("wb_data", wb_data_o, e_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] instr, input logic [IW-1:0] id);
        req_valid = 1'b1; req_instr = instr; req_rs1 = instr ^ 32'h1111_0000;
        req_rs2 = ~instr; req_id = id;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_issue(input logic acc, input logic wb, input logic k);
        issue_ready = 1'b1; issue_accept = acc; issue_writeback = wb; kill = k;
        step();
        issue_ready = 1'b0; issue_accept = 1'b0; issue_writeback = 1'b0; kill = 1'b0;
    endtask

    task automatic send_result(input logic [IW-1:0] id, input logic [XW-1:0] data,
                               input logic [4:0] rd, input logic we, input logic exc);
        result_valid = 1'b1; result_id = id; result_data = data;
        result_rd = rd; result_we = we; result_exc = exc;
        step();
        result_valid = 1'b0; result_we = 1'b0; result_exc = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("lit reset req_ready", req_ready_o, 1'b1);
        chk("lit reset busy", busy_o, 1'b0);
        chk("lit reset issue_valid", issue_valid_o, 1'b0);
        chk("lit reset issue_instr", issue_instr_o, 32'h0);
        rst = 1'b0;

        // Back-to-back accepted instruction at the minimum 4-cycle interval.
        send_req(32'h0000_000B, 4'd3);
        chk("lit issue_valid", issue_valid_o, 1'b1);
        chk("lit issue_rs0", issue_rs0_o, 32'h1111_000B);
        chk("lit issue_id", issue_id_o, 4'd3);
        do_issue(1'b1, 1'b1, 1'b0);
        chk("lit commit_valid", commit_valid_o, 1'b1);
        chk("lit commit_id", commit_id_o, 4'd3);
        chk("lit commit_kill", commit_kill_o, 1'b0);
        step();
        send_result(4'd3, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0);
        chk("lit wb_valid", wb_valid_o, 1'b1);
        chk("lit wb_rd", wb_rd_o, 5'd5);
        chk("lit wb_data", wb_data_o, 32'hDEAD_BEEF);
        chk("lit req_ready after wb", req_ready_o, 1'b1);

        // Rejected instruction.
        send_req(32'h0000_002B, 4'd1);
        do_issue(1'b0, 1'b0, 1'b0);
        chk("lit illegal", illegal_o, 1'b1);
        chk("lit illegal no commit", commit_valid_o, 1'b0);
        chk("lit illegal req_ready", req_ready_o, 1'b1);
        step();
        chk("lit illegal one pulse", illegal_o, 1'b0);

        // Stalled issue with a kill in the second cycle.
        send_req(32'h0000_005B, 4'd2);
        step();
        kill = 1'b1; step(); kill = 1'b0;
        step(); step(); step();
        chk("lit stalled issue_instr", issue_instr_o, 32'h0000_005B);
        do_issue(1'b1, 1'b1, 1'b0);
        chk("lit killed commit", commit_kill_o, 1'b1);
        step();
        chk("lit killed idle", req_ready_o, 1'b1);
        chk("lit killed no wb", wb_valid_o, 1'b0);

        // Kill coincident with the issue handshake.
        send_req(32'h0000_007B, 4'd5);
        do_issue(1'b1, 1'b1, 1'b1);
        chk("lit kill at handshake", commit_kill_o, 1'b1);
        step();

        // Mismatching id then matching id.
        send_req(32'h0000_000B, 4'd3);
        do_issue(1'b1, 1'b1, 1'b0);
        step();
        send_result(4'd7, 32'h1234_5678, 5'd6, 1'b1, 1'b0);
        chk("lit id_err", id_err_o, 1'b1);
        chk("lit id_err busy", busy_o, 1'b1);
        send_result(4'd3, 32'hCAFE_F00D, 5'd9, 1'b1, 1'b0);
        chk("lit id_err then wb", wb_data_o, 32'hCAFE_F00D);
        chk("lit id_err single", id_err_o, 1'b0);

        // Timeout after TO result cycles.
        send_req(32'h0000_000B, 4'd4);
        do_issue(1'b1, 1'b1, 1'b0);
        step();
        repeat (TO - 1) step();
        chk("lit no early timeout", timeout_o, 1'b0);
        step();
        chk("lit timeout", timeout_o, 1'b1);
        chk("lit timeout idle", req_ready_o, 1'b1);

        // Exception result.
        send_req(32'h0000_000B, 4'd4);
        do_issue(1'b1, 1'b1, 1'b0);
        step();
        send_result(4'd4, 32'hAAAA_5555, 5'd5, 1'b1, 1'b1);
        chk("lit exc", exc_o, 1'b1);
        chk("lit exc no wb", wb_valid_o, 1'b0);

        // rd = 0 suppresses writeback.
        send_req(32'h0000_000B, 4'd4);
        do_issue(1'b1, 1'b1, 1'b0);
        step();
        send_result(4'd4, 32'h5555_AAAA, 5'd0, 1'b1, 1'b0);
        chk("lit rd0 no wb", wb_valid_o, 1'b0);

        // Matching result on the terminal-count cycle wins over the timeout.
        send_req(32'h0000_000B, 4'd4);
        do_issue(1'b1, 1'b1, 1'b0);
        step();
        repeat (TO - 1) step();
        send_result(4'd4, 32'h0BAD_F00D, 5'd12, 1'b1, 1'b0);
        chk("lit tc result no timeout", timeout_o, 1'b0);
        chk("lit tc result wb", wb_valid_o, 1'b1);

        // Coprocessor declined writeback.
        send_req(32'h0000_000B, 4'd6);
        do_issue(1'b1, 1'b0, 1'b0);
        step();
        send_result(4'd6, 32'h7777_7777, 5'd3, 1'b1, 1'b0);
        chk("lit no wb flag", wb_valid_o, 1'b0);

        // Reset while waiting for a result.
        send_req(32'h0000_000B, 4'd2);
        do_issue(1'b1, 1'b1, 1'b0);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("lit rst req_ready", req_ready_o, 1'b1);
        chk("lit rst busy", busy_o, 1'b0);
        chk("lit rst result_ready", result_ready_o, 1'b0);
        chk("lit rst commit_kill", commit_kill_o, 1'b0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
